// File: rtl/register_bank_2r1w.sv
// Two-read, one-write register bank with registered read ports, optional zero register and write forwarding.
// Latency: writes land on the next edge; reads strobed by rd_en appear on busA/busB after the same edge.
// Backpressure: none; rd_valid pulses once per rd_en, and the read outputs hold while rd_en is low.
//
// Ports:
//   clk, rst                     single clock, synchronous active-high reset
//   wr_en, w_addr, w_data        write port (bus C)
//   rd_en, a_addr, b_addr        read strobe and the two read addresses
//   busA, busB, rd_valid         registered read data and its one-cycle valid
//   a_written, b_written         registered "entry written since reset" status per port
module register_bank_2r1w #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter bit          ZERO_REG   = 1'b0,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic [DATA_WIDTH-1:0] busA,
    output logic [DATA_WIDTH-1:0] busB,
    output logic                  rd_valid,
    output logic                  a_written,
    output logic                  b_written
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      written;

    logic                  wr_eff;
    logic                  a_zero, b_zero;
    logic                  a_fwd, b_fwd;
    logic [DATA_WIDTH-1:0] a_data, b_data;
    logic                  a_flag, b_flag;

    // Writes to the hardwired-zero register are dropped here, which also
    // keeps them from being forwarded to a read port.
    always_comb begin
        wr_eff = wr_en;
        if (ZERO_REG && (w_addr == '0)) begin
            wr_eff = 1'b0;
        end
    end

    // Read-side selection: zero register first, then forwarding, then storage.
    // Storage is read before this edge's write, so BYPASS=0 gives old data.
    always_comb begin
        a_zero = ZERO_REG && (a_addr == '0);
        b_zero = ZERO_REG && (b_addr == '0);
        a_fwd  = BYPASS && wr_eff && (w_addr == a_addr);
        b_fwd  = BYPASS && wr_eff && (w_addr == b_addr);

        a_data = mem[a_addr];
        a_flag = written[a_addr];
        if (a_zero) begin
            a_data = '0;
            a_flag = 1'b1;
        end else if (a_fwd) begin
            a_data = w_data;
            a_flag = 1'b1;
        end

        b_data = mem[b_addr];
        b_flag = written[b_addr];
        if (b_zero) begin
            b_data = '0;
            b_flag = 1'b1;
        end else if (b_fwd) begin
            b_data = w_data;
            b_flag = 1'b1;
        end
    end

    // Storage and written flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            written <= '0;
        end else if (wr_eff) begin
            mem[w_addr]     <= w_data;
            written[w_addr] <= 1'b1;
        end
    end

    // Registered read ports; data and status hold while rd_en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            busA      <= '0;
            busB      <= '0;
            a_written <= 1'b0;
            b_written <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                busA      <= a_data;
                busB      <= b_data;
                a_written <= a_flag;
                b_written <= b_flag;
            end
        end
    end

endmodule

// File: doc/register_bank_2r1w.md
# register_bank_2r1w

Parametrised two-read, one-write register bank: the next generation of the 8 x 8-bit `register_bank` used on the datapath bus structure (write on bus C, read on buses A and B). Depth, width, an optional hardwired-zero register and write-to-read forwarding are selectable. Read ports are registered and gated by a read strobe. Per-port "written since reset" status flags let control logic detect reads of uninitialised registers.

## Interface
- `DATA_WIDTH`, default 8: register and bus width in bits, ≥1.
- `ADDR_WIDTH`, default 3: address width; depth is `DEPTH = 2**ADDR_WIDTH`.
- `ZERO_REG`, default 0: when 1, register 0 is hardwired to zero.
- `BYPASS`, default 1: when 1, a same-cycle write to the read address is forwarded to the read port.
- `clk`  in  1  — single clock; all state changes on its rising edge.
- `rst`  in  1  — reset; synchronous, active-high.
- `wr_en`  in  1  — write strobe for bus C.
- `w_addr`  in  ADDR_WIDTH  — write address (bus C address).
- `w_data`  in  DATA_WIDTH  — write data (bus C).
- `rd_en`  in  1  — read strobe; captures both read ports.
- `a_addr`  in  ADDR_WIDTH  — bus A read address.
- `b_addr`  in  ADDR_WIDTH  — bus B read address.
- `busA`  out  DATA_WIDTH  — registered bus A read data.
- `busB`  out  DATA_WIDTH  — registered bus B read data.
- `rd_valid`  out  1  — high for one cycle when `busA`/`busB` carry data captured on the previous edge.
- `a_written`  out  1  — registered; the register read onto `busA` had been written since reset.
- `b_written`  out  1  — same as `a_written`, for `busB`.

## Operation
- Storage: `DEPTH` entries of `DATA_WIDTH` bits, plus a `DEPTH`-bit written-flag vector.
- Reset, when `rst`=1 at the edge:
  - All entries go to 0 and all written flags to 0.
  - `busA`, `busB`, `rd_valid`, `a_written` and `b_written` go to 0.
  - `rst` overrides `wr_en` and `rd_en` in the same cycle.
- Write, when `wr_en`=1:
  - Entry `w_addr` takes `w_data` and its written flag is set.
  - With `ZERO_REG`=1 and `w_addr`=0, the write is silently dropped.
- Read, when `rd_en`=1:
  - Each port is captured independently: `busX <= entry[x_addr]`.
  - The port's written flag is captured alongside the data.
  - `a_addr` and `b_addr` may be equal; both ports then return the same value.
- Forwarding, when `BYPASS`=1 and `wr_en`=1 with `w_addr` equal to the port address (and that address not the zero register):
  - The port captures `w_data`, and its written output is 1.
  - This applies to either port or both.
- No forwarding, when `BYPASS`=0: a same-cycle read returns the old contents (read-before-write) and the old flag.
- Zero register, when `ZERO_REG`=1 and a read address is 0: the port returns 0, its written output is 1, and no forwarding applies.
- When `rd_en`=0: `busA`, `busB`, `a_written` and `b_written` hold their values, and `rd_valid` goes to 0 on that edge.
- Addresses cover the full power-of-two range; no out-of-range case exists.

## Timing
- Write latency: 1 edge. Data written at edge N is readable by a read strobed at edge N+1; it appears on the bus after edge N+1.
- Read latency: 1 edge. Address and `rd_en` sampled at edge N produce `busX` and `rd_valid`=1 after edge N.
- A forwarded read also appears after edge N, the same edge as the write.
- `rd_valid` is a pulse per strobe. Back-to-back `rd_en` gives a continuous `rd_valid` with new data every cycle.
- There are no combinational paths from inputs to outputs.
- Reset asserted mid-stream: outputs read 0 after the reset edge. The first read after reset release returns 0 with the written flag at 0 (unless the zero register or forwarding applies).

## Test plan
- Write/readback sweep (defaults). Write entry i = {0xCC,0x33,0xAA,0x55,0x0F,0xF0,0x99,0x66} for i = 0..7, then read with `a_addr`=i and `b_addr`=7−i. Required: busA=entry[i], busB=entry[7−i], rd_valid=1 one cycle after each strobe, both written flags 1.
- Forwarding. With `BYPASS`=1: write 0x7E to entry 5 while reading a=5, b=3, where entry 3 holds 0x55. Required next cycle: busA=0x7E, busB=0x55. Repeat with `BYPASS`=0 and old entry 5 = 0xF0: required busA=0xF0.
- Zero register. With `ZERO_REG`=1: write 0xFF to address 0, then read a=0. Required: busA=0x00, a_written=1. With `ZERO_REG`=0 the same sequence requires busA=0xFF.
- Read strobe hold. Read entry 2 (0xAA), then drop `rd_en` and write entry 2 = 0x11. Required: busA stays 0xAA and rd_valid=0 until the next strobe, which returns 0x11.
- Reset mid-operation. Fill all entries, then assert `rst` for one cycle with `wr_en`=1, `rd_en`=1. Required:
  - The write is ignored, and all outputs are 0 after the edge.
  - A subsequent read of any address returns 0 with a_written=b_written=0.
- Parametrisation. Run with `DATA_WIDTH`=16, `ADDR_WIDTH`=4. Write 0xBEEF to entry 15 and 0x1234 to entry 8, then read a=15, b=8. Required: busA=0xBEEF, busB=0x1234.
